// File: rtl/btn_uart_tx.sv
// btn_uart_tx: sends one UART frame (7/8 data bits, optional even/odd parity,
// one stop bit) of the switch value on each rising edge of the debounced button.
module btn_uart_tx #(
  parameter int BIT_TICKS = 10417
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       db_btn,
  input  logic [7:0] data_sw,
  input  logic       eight,
  input  logic       pen,
  input  logic       ohel,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int TW = (BIT_TICKS > 2) ? $clog2(BIT_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_nx;
  logic [TW-1:0] tick, tick_nx;
  logic [2:0]    bit_idx, bit_idx_nx;
  logic [2:0]    bit_idx_inc;
  logic          prev;
  logic [7:0]    f_data, f_data_nx;
  logic          f_eight, f_eight_nx;
  logic          f_pen, f_pen_nx;
  logic          f_ohel, f_ohel_nx;
  logic          tx_nx, busy_nx, done_nx;
  logic          start, bit_end, last_bit, par_bit;

  assign start       = db_btn & ~prev & (state == IDLE);
  assign bit_end     = (tick == TICK_LAST);
  assign last_bit    = (bit_idx == (f_eight ? 3'd7 : 3'd6));
  assign bit_idx_inc = bit_idx + 3'd1;
  // Bit 7 is masked out of the parity in 7-bit mode; odd parity inverts it.
  assign par_bit     = (^(f_data & {f_eight, 7'h7f})) ^ f_ohel;

  // State, counters, frame register and registered outputs.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tick    <= '0;
      bit_idx <= '0;
      prev    <= 1'b1;
      f_data  <= '0;
      f_eight <= 1'b0;
      f_pen   <= 1'b0;
      f_ohel  <= 1'b0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_nx;
      tick    <= tick_nx;
      bit_idx <= bit_idx_nx;
      prev    <= db_btn;
      f_data  <= f_data_nx;
      f_eight <= f_eight_nx;
      f_pen   <= f_pen_nx;
      f_ohel  <= f_ohel_nx;
      tx      <= tx_nx;
      tx_busy <= busy_nx;
      tx_done <= done_nx;
    end
  end

  // Next-state logic; tx is computed one cycle ahead so the pin is registered.
  always_comb begin
    state_nx   = state;
    tick_nx    = (state == IDLE || bit_end) ? '0 : tick + 1'b1;
    bit_idx_nx = bit_idx;
    f_data_nx  = f_data;
    f_eight_nx = f_eight;
    f_pen_nx   = f_pen;
    f_ohel_nx  = f_ohel;
    tx_nx      = tx;
    busy_nx    = tx_busy;
    done_nx    = 1'b0;
    case (state)
      IDLE: begin
        tx_nx = 1'b1;
        if (start) begin
          f_data_nx  = data_sw;
          f_eight_nx = eight;
          f_pen_nx   = pen;
          f_ohel_nx  = ohel;
          state_nx   = START;
          tx_nx      = 1'b0;
          busy_nx    = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_nx   = DATA;
          bit_idx_nx = '0;
          tx_nx      = f_data[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (last_bit) begin
            if (f_pen) begin
              state_nx = PARITY;
              tx_nx    = par_bit;
            end else begin
              state_nx = STOP;
              tx_nx    = 1'b1;
            end
          end else begin
            bit_idx_nx = bit_idx_inc;
            tx_nx      = f_data[bit_idx_inc];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nx = STOP;
          tx_nx    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_nx = IDLE;
          tx_nx    = 1'b1;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        tx_nx    = 1'b1;
        busy_nx  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_btn_uart_tx.sv
// Scoreboard bench for btn_uart_tx: presses push expected frames, a monitor
// checks the tx waveform, busy window and done pulse of each frame it sees.
module tb_btn_uart_tx;

  localparam int BT = 16;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       db_btn;
  logic [7:0] data_sw;
  logic       eight, pen, ohel;
  logic       tx, tx_busy, tx_done;

  btn_uart_tx #(.BIT_TICKS(BT)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .db_btn (db_btn),
    .data_sw(data_sw),
    .eight  (eight),
    .pen    (pen),
    .ohel   (ohel),
    .tx     (tx),
    .tx_busy(tx_busy),
    .tx_done(tx_done)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int         e;
    int         len;
    logic [10:0] bits;
  } frame_t;

  frame_t exp_q[$];
  frame_t cur;
  bit     active = 1'b0;
  int     cyc = 0;
  int     frame_end = 0;
  int     last_e = 0;
  int     n_chk = 0;
  int     n_fail = 0;

  always @(posedge clk_in) cyc = cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endfunction

  // Reference frame: start bit, N data bits LSB first, optional parity, stop bit.
  function automatic frame_t mk(int e, logic [7:0] d, logic e8, logic p, logic o);
    frame_t f;
    int n, ones, k;
    n = e8 ? 8 : 7;
    ones = 0;
    f.bits = '0;
    f.e = e;
    for (int i = 0; i < n; i++) begin
      f.bits[1 + i] = d[i];
      ones += int'(d[i]);
    end
    k = 1 + n;
    if (p) begin
      f.bits[k] = ((ones % 2) == 1) ^ o;
      k++;
    end
    f.bits[k] = 1'b1;
    f.len = (k + 1) * BT;
    return f;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic goto(input int t);
    while (cyc < t) step(1);
  endtask

  task automatic wait_idle();
    while (cyc <= frame_end) step(1);
  endtask

  task automatic cfg(input logic [7:0] d, input logic e8, input logic p, input logic o);
    data_sw = d;
    eight   = e8;
    pen     = p;
    ohel    = o;
  endtask

  // Rising edge sampled at the next clock edge; accepted only if the model is idle there.
  task automatic press(input int hold);
    frame_t f;
    int e;
    e = cyc + 1;
    db_btn = 1'b1;
    if (e > frame_end) begin
      f = mk(e, data_sw, eight, pen, ohel);
      exp_q.push_back(f);
      frame_end = e + f.len;
      last_e = e;
    end
    step(hold);
    db_btn = 1'b0;
    step(1);
  endtask

  // Monitor: follows each frame the DUT presents and compares it to the scoreboard.
  initial begin
    int off;
    forever begin
      @(negedge clk_in);
      if (reset) begin
        active = 1'b0;
        chk("reset_tx", tx, 1);
        chk("reset_busy", tx_busy, 0);
        chk("reset_done", tx_done, 0);
      end else begin
        if (active) begin
          off = cyc - cur.e;
          if (off < cur.len) begin
            chk("tx_bit", tx, cur.bits[off / BT]);
            chk("busy_in_frame", tx_busy, 1);
            chk("done_in_frame", tx_done, 0);
          end else if (off == cur.len) begin
            chk("done_pulse", tx_done, 1);
            chk("busy_at_end", tx_busy, 0);
            chk("tx_at_end", tx, 1);
          end else begin
            chk("done_one_cycle", tx_done, 0);
            active = 1'b0;
          end
        end
        if (!active) begin
          if (tx_busy) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_frame", 1, 0);
            end else begin
              cur = exp_q.pop_front();
              chk("frame_start_cycle", cyc, cur.e);
              active = 1'b1;
            end
          end else begin
            chk("idle_tx", tx, 1);
            chk("idle_done", tx_done, 0);
          end
        end
      end
    end
  end

  initial begin
    #1500000;
    n_fail++;
    $display("FAIL watchdog: stimulus did not complete, cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    reset  = 1'b1;
    db_btn = 1'b0;
    cfg(8'h00, 1'b1, 1'b0, 1'b0);
    step(3);
    chk("por_tx", tx, 1);
    chk("por_busy", tx_busy, 0);
    chk("por_done", tx_done, 0);
    reset = 1'b0;
    step(3);

    // 8N1 0x55, 8E1 0x07, 7O1 0xC1
    cfg(8'h55, 1'b1, 1'b0, 1'b0); press(3); wait_idle(); step(5);
    cfg(8'h07, 1'b1, 1'b1, 1'b0); press(3); wait_idle(); step(5);
    cfg(8'hC1, 1'b0, 1'b1, 1'b1); press(3); wait_idle(); step(5);

    // Second rise and switch change mid-frame are ignored; rise after done is accepted.
    cfg(8'h55, 1'b1, 1'b0, 1'b0); press(3);
    e = last_e;
    goto(e + 39); press(2);
    goto(e + 50); data_sw = 8'hAA;
    wait_idle();
    goto(frame_end + 4); press(3);
    chk("second_frame_start", last_e, frame_end - 160);
    wait_idle(); step(5);

    // Reset mid-frame aborts at once.
    cfg(8'h3C, 1'b1, 1'b0, 1'b0); press(3);
    e = last_e;
    goto(e + 69);
    reset = 1'b1;
    #1;
    chk("abort_tx", tx, 1);
    chk("abort_busy", tx_busy, 0);
    chk("abort_done", tx_done, 0);
    step(2);
    reset = 1'b0;
    frame_end = 0;
    step(3);

    // Button held across reset release sends nothing until a fresh rise.
    db_btn = 1'b1;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(200);
    db_btn = 1'b0;
    step(2);
    cfg(8'hA5, 1'b1, 1'b1, 1'b1); press(3); wait_idle(); step(5);

    // Randomized frames with random mid-frame presses and switch changes.
    for (int i = 0; i < 12; i++) begin
      cfg(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      press($urandom_range(1, 5));
      if ($urandom_range(0, 1) == 1) begin
        step($urandom_range(5, 150));
        cfg(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        press(2);
      end
      wait_idle();
      step($urandom_range(0, 20));
    end

    wait_idle();
    step(5);
    chk("queue_drained", exp_q.size(), 0);
    chk("monitor_idle", active, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_uart_tx.md
# btn_uart_tx

Transmit front end that consumes the debounced push-button level produced by the debounce stage. On each rising edge of the debounced level it captures one character from the board switches and serialises it as an asynchronous UART frame on `tx`. Frame format is 7 or 8 data bits with optional even or odd parity and one stop bit. It sits between the debounce stage and the board TX pin, and also drives status LEDs.

## Interface
- `BIT_TICKS`, default 10417: `clk_in` cycles per bit (9600 baud at 100 MHz). Legal range is 2 or more. The tick counter width is ceil(log2(BIT_TICKS)).
- `clk_in`  in  1  system clock, 100 MHz nominal.
- `reset`  in  1  asynchronous, active-high reset.
- `db_btn`  in  1  debounced button level, synchronous to `clk_in`, from the debounce stage.
- `data_sw`  in  8  character to send. Bit 7 is ignored in 7-bit mode.
- `eight`  in  1  1 = 8 data bits, 0 = 7 data bits.
- `pen`  in  1  parity enable.
- `ohel`  in  1  parity select when `pen`=1: 1 = odd, 0 = even.
- `tx`  out  1  serial output, idle high.
- `tx_busy`  out  1  high while a frame is in progress.
- `tx_done`  out  1  one-cycle pulse at frame completion.

## Operation
- Reset is asynchronous, active-high; clock is `clk_in`. While reset is asserted:
  - `tx`=1, `tx_busy`=0, `tx_done`=0.
  - State=IDLE and all counters=0.
  - Edge register `prev`=1, so a button held through reset release sends nothing.
- Edge detect: `prev` <= `db_btn` every cycle. Start condition is `db_btn`=1, `prev`=0 and state=IDLE.
- On the start condition, latch `data_sw`, `eight`, `pen` and `ohel` into a frame register. Input changes mid-frame have no effect.
- Rising edges seen while busy are discarded, not queued.
- FSM states, all outputs registered:
  - IDLE: `tx`=1. Go to START on the start condition.
  - START: `tx`=0 for BIT_TICKS cycles, then go to DATA.
  - DATA: `tx`=data bit i, LSB first, i = 0 to N-1, where N = 8 if `eight` else 7. Each bit lasts BIT_TICKS cycles. After bit N-1, go to PARITY if `pen`, else STOP.
  - PARITY: `tx` = XOR of the N sent bits, inverted when `ohel`=1. Lasts BIT_TICKS cycles, then go to STOP.
  - STOP: `tx`=1 for BIT_TICKS cycles, then go to IDLE.
- Tick counter counts 0 to BIT_TICKS-1. The bit advances on the cycle the counter equals BIT_TICKS-1, and the counter wraps to 0 there.
- Bit index counter is 3 bits and is cleared on entry to DATA.
- Frame length L = (2 + N + pen) × BIT_TICKS cycles.
- Reset mid-frame aborts the frame immediately. `tx` returns high asynchronously, and no `tx_done` pulse is produced.

## Timing
- Let E be the clock edge at which the start condition is sampled.
  - From E: `tx`=0 and `tx_busy`=1.
  - From E+BIT_TICKS: data bit 0 is on `tx`.
- At edge E+L:
  - state=IDLE, `tx_busy`=0, `tx_done`=1 for exactly one cycle.
  - `tx` remains 1.
- The earliest next frame starts at edge E+L+1. This requires a fresh 0-to-1 transition of `db_btn` that is sampled while in IDLE.
- If `db_btn` rises on the same edge that the frame ends (edge E+L), the start condition is not met because state ≠ IDLE. That edge is lost, and this is the required behaviour.
- `db_btn` is assumed to have no glitches; no additional synchroniser is used.

## Test plan
All scenarios use BIT_TICKS=16.
- 8N1, `data_sw`=0x55, single `db_btn` rise:
  - `tx` sequence 0,1,0,1,0,1,0,1,0,1, each bit 16 cycles.
  - `tx_busy` high for 160 cycles.
  - `tx_done` pulse at E+160.
- 8E1, `data_sw`=0x07:
  - data bits 1,1,1,0,0,0,0,0, then parity bit 1, then stop.
  - `tx_done` at E+176.
- 7O1, `data_sw`=0xC1:
  - 7 data bits 1,0,0,0,0,0,1; bit 7 is not sent.
  - parity bit 1 (two ones, odd).
  - `tx_done` at E+160.
- During a frame:
  - a second `db_btn` rise at E+40 and a `data_sw` change at E+50 leave the waveform identical to the single-press case.
  - no second frame is sent.
  - a rise 5 cycles after `tx_done` sends a second frame.
- Reset at E+70 mid-frame: `tx`=1 and `tx_busy`=0 immediately, with no `tx_done`.
- `db_btn` held high across reset release: no frame is sent. After `db_btn` falls and rises again, exactly one frame is sent.
